// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 Booth multiplier.
// Each BUSY cycle retires one Booth partial product. An optional low-column
// truncation mode is available. Valid/ready handshakes are used on both the
// operand side and the result side.
module booth_r4_mult_seq #(
    parameter int N        = 16,
    parameter int APPROX_K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           tc,
    input  logic           approx_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(N / 2 + 2);

    // Columns below APPROX_K are dropped from every partial product in approximate mode
    localparam logic [W-1:0] LOW_ONES  = (W'(1) << APPROX_K) - W'(1);
    localparam logic [W-1:0] KEEP_MASK = ~LOW_ONES;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   acc;
    logic [W-1:0]   mcand;      // A * 4^i, modulo 2^W
    logic [N+2:0]   bsh;        // {ext2, b, 1'b0}, shifted right two bits per digit
    logic           tc_r;
    logic           approx_r;
    logic [CW-1:0]  idx;
    logic           last;
    logic           accept;
    logic           neg;
    logic           dbl;
    logic           nz;
    logic [W-1:0]   mx;
    logic [W-1:0]   pp_full;
    logic [W-1:0]   pp_used;

    assign accept = in_valid && in_ready;
    assign last   = (idx == (tc_r ? CW'(N / 2 - 1) : CW'(N / 2)));
    assign result = acc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the handshake outputs are decoded from the registered state only
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Booth digit recoding from the triplet {b[2i+1], b[2i], b[2i-1]}
    always_comb begin
        neg = 1'b0;
        dbl = 1'b0;
        nz  = 1'b0;
        case (bsh[2:0])
            3'b001, 3'b010: nz = 1'b1;
            3'b011:         begin nz = 1'b1; dbl = 1'b1; end
            3'b100:         begin nz = 1'b1; dbl = 1'b1; neg = 1'b1; end
            3'b101, 3'b110: begin nz = 1'b1; neg = 1'b1; end
            default:        nz = 1'b0;
        endcase
    end

    // Partial product: the invert-plus-one negation is completed in the same cycle.
    // The mask is applied to the complete two's-complement value.
    always_comb begin
        mx      = nz ? (dbl ? (mcand << 1) : mcand) : '0;
        pp_full = (mx ^ {W{neg}}) + W'(neg);
        pp_used = approx_r ? (pp_full & KEEP_MASK) : pp_full;
    end

    // Operand capture at accept, then one digit accumulated per BUSY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            mcand    <= '0;
            bsh      <= '0;
            tc_r     <= 1'b0;
            approx_r <= 1'b0;
            idx      <= '0;
        end else if (accept) begin
            acc      <= '0;
            mcand    <= {{N{tc & a[N-1]}}, a};
            bsh      <= {(tc ? {2{b[N-1]}} : 2'b00), b, 1'b0};
            tc_r     <= tc;
            approx_r <= approx_en;
            idx      <= '0;
        end else if (state == BUSY) begin
            acc   <= acc + pp_used;
            mcand <= mcand << 2;
            bsh   <= bsh >> 2;
            idx   <= idx + CW'(1);
        end
    end

endmodule
